alu: RTL and testbench
======================

# alu

Combinational execute unit for the single-cycle RV32I core: given decoded operands, instruction class (`input_type`) and per-class operation code (`alu_control`), it produces the register write-back value, data-memory address/data/byte-enables, memory valids and branch target. Instantiated inside `control`, which feeds `iaddr_val` back into its next-PC logic in the same cycle. Only the status flags are registered.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `read_data1`, `read_data2` in 32: rs1 / rs2 values.
- `imm` in 32: immediate, already sign-extended or shifted by decoder.
- `alu_control` in 4: operation code within class.
- `input_type` in 4: 0 R, 1 I, 2 Load, 3 Store, 4 Branch, 5 JALR, 6 JAL, 7 AUIPC, 8 LUI.
- `data_read` in 32: data-memory read word.
- `instruction_addr` in 32: PC of current instruction.
- `reg_write_data` out 32: rd write-back value.
- `register_write_valid` out 1: rd write enable.
- `data_addr` out 32: memory byte address.
- `data_write` out 32: store data, lane-aligned.
- `data_write_byte` out 4: store byte enables.
- `data_read_valid`, `data_write_valid` out 1: load / store strobes.
- `iaddr_val` out 32: next PC for branches (target or PC+4).
- `zero_flag`, `negative_flag`, `overflow_flag` out 1: registered status.

## Operation
- Defaults every cycle: all valids 0, `data_write_byte`=0, `data_write`=0, `data_addr`=0, `reg_write_data`=0, `iaddr_val`=PC+4.
- R (type 0), a=rs1, b=rs2; I (type 1), b=imm. Set `register_write_valid`.
  - R codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - I codes: 0 ADDI, 1 SLLI, 2 SLTI, 3 SLTIU, 4 XORI, 5 SRLI, 6 SRAI, 7 ORI, 8 ANDI.
  - Shift amount = b[4:0]; SLT/SLTU yield 32'd1/0.
- Load (2): `data_addr`=rs1+imm; `data_read_valid`=1; `register_write_valid`=1. Codes 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU. Byte lane = addr[1:0]; half lane = addr[1] (addr[0] ignored); LW ignores addr[1:0]. Sign-/zero-extend to 32.
- Store (3): `data_addr`=rs1+imm; `data_write_valid`=1. SB(0): mask 4'b0001<<addr[1:0], data=rs2[7:0]<<8·addr[1:0]. SH(1): mask 0011/1100 by addr[1], data=rs2[15:0]<<16·addr[1]. SW(2): mask 1111, data=rs2.
- Branch (4): codes 0 BEQ, 1 BNE, 4 BLT, 6 BGE, 7 BLTU, 8 BGEU; taken → `iaddr_val`=PC+imm, else PC+4. No write-back.
- JALR (5), JAL (6): rd=PC+4, write valid 1. AUIPC (7): rd=PC+imm. LUI (8): rd=imm.
- Undefined type/code: defaults (no writes, no memory access, `iaddr_val`=PC+4).
- All arithmetic modulo 2^32.

## Timing
- All outputs except flags combinational, zero latency.
- Flags updated on posedge clk: zero = (main result==0), negative = result[31], overflow = signed overflow of ADD/ADDI/SUB (else 0). For branches, result = rs1−rs2.
- reset high at posedge: all three flags ← 0 (priority over update). Flags power up 0.
- Combinational outputs unaffected by reset.

## Structure
- Shared package `rv_pkg`: `input_type` enum and per-class `alu_control` code constants.
- Optional sub-module `alu_lsu_align` for load extraction / store lane and mask generation; rest is flat.

## Test plan
- Type 0 code 0, rs1=11, rs2=22 → `reg_write_data`=33, write valid 1; code 1 → 0xFFFFFFF5, next edge negative_flag=1.
- Type 0 ADD 0x7FFFFFFF+1 → 0x80000000; next edge overflow_flag=1, negative_flag=1.
- Load, rs1=0, imm=0, data_read=0x80000080: code 0 → 0xFFFFFF80, code 3 → 0x00000080, `data_read_valid`=1.
- Store SB, rs1=11, imm=5, rs2=0xAB → `data_addr`=16, mask 0001, data 0xAB; rs1=13 → mask 0100, data 0x00AB0000.
- Branch PC=0x100, imm=0x10, rs1=rs2=5: BEQ → 0x110, BNE → 0x104; BLTU rs1=1, rs2=0xFFFFFFFF → 0x110, BLT → 0x104.
- JAL PC=0x40 → rd 0x44; LUI imm=0x12345000 → 0x12345000; reset high → flags 0 next edge.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I execute-stage shared types: instruction classes, per-class op codes, ALU op decode.
// Latency: n/a (package only).
// Backpressure: n/a.
package rv_pkg;

    typedef enum logic [3:0] {
        IT_R      = 4'd0,
        IT_I      = 4'd1,
        IT_LOAD   = 4'd2,
        IT_STORE  = 4'd3,
        IT_BRANCH = 4'd4,
        IT_JALR   = 4'd5,
        IT_JAL    = 4'd6,
        IT_AUIPC  = 4'd7,
        IT_LUI    = 4'd8
    } input_type_e;

    localparam logic [3:0] R_ADD  = 4'd0, R_SUB = 4'd1, R_SLL = 4'd2, R_SLT = 4'd3,
                           R_SLTU = 4'd4, R_XOR = 4'd5, R_SRL = 4'd6, R_SRA = 4'd7,
                           R_OR   = 4'd8, R_AND = 4'd9;

    localparam logic [3:0] I_ADDI = 4'd0, I_SLLI = 4'd1, I_SLTI = 4'd2, I_SLTIU = 4'd3,
                           I_XORI = 4'd4, I_SRLI = 4'd5, I_SRAI = 4'd6, I_ORI   = 4'd7,
                           I_ANDI = 4'd8;

    localparam logic [3:0] LD_LB = 4'd0, LD_LH = 4'd1, LD_LW = 4'd2, LD_LBU = 4'd3, LD_LHU = 4'd4;

    localparam logic [3:0] ST_SB = 4'd0, ST_SH = 4'd1, ST_SW = 4'd2;

    localparam logic [3:0] BR_BEQ = 4'd0, BR_BNE = 4'd1, BR_BLT  = 4'd4,
                           BR_BGE = 4'd6, BR_BLTU = 4'd7, BR_BGEU = 4'd8;

    // R and I classes number their operations differently; fold both onto one op set.
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_NONE
    } alu_op_e;

    function automatic alu_op_e decode_alu_op(input input_type_e typ, input logic [3:0] code);
        alu_op_e op;
        op = OP_NONE;
        if (typ == IT_R) begin
            case (code)
                R_ADD:   op = OP_ADD;
                R_SUB:   op = OP_SUB;
                R_SLL:   op = OP_SLL;
                R_SLT:   op = OP_SLT;
                R_SLTU:  op = OP_SLTU;
                R_XOR:   op = OP_XOR;
                R_SRL:   op = OP_SRL;
                R_SRA:   op = OP_SRA;
                R_OR:    op = OP_OR;
                R_AND:   op = OP_AND;
                default: op = OP_NONE;
            endcase
        end else if (typ == IT_I) begin
            case (code)
                I_ADDI:  op = OP_ADD;
                I_SLLI:  op = OP_SLL;
                I_SLTI:  op = OP_SLT;
                I_SLTIU: op = OP_SLTU;
                I_XORI:  op = OP_XOR;
                I_SRLI:  op = OP_SRL;
                I_SRAI:  op = OP_SRA;
                I_ORI:   op = OP_OR;
                I_ANDI:  op = OP_AND;
                default: op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_lsu_align.sv
// Load lane extraction with sign/zero extension, store lane placement and byte-enable generation.
// Latency: combinational, zero cycles.
// Backpressure: none; no handshake.
module alu_lsu_align
    import rv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  code,
    input  logic [31:0] data_read,
    input  logic [31:0] store_src,
    output logic [31:0] load_data,
    output logic        load_ok,
    output logic [31:0] store_data,
    output logic [3:0]  store_mask,
    output logic        store_ok
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(data_read >> {addr_lo, 3'b000});
    assign half_sel = addr_lo[1] ? data_read[31:16] : data_read[15:0];

    always_comb begin
        load_data = '0;
        load_ok   = 1'b1;
        case (code)
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LD_LW:   load_data = data_read;
            LD_LBU:  load_data = {24'b0, byte_sel};
            LD_LHU:  load_data = {16'b0, half_sel};
            default: load_ok   = 1'b0;
        endcase
    end

    always_comb begin
        store_data = '0;
        store_mask = '0;
        store_ok   = 1'b1;
        case (code)
            ST_SB: begin
                store_mask = 4'b0001 << addr_lo;
                store_data = {24'b0, store_src[7:0]} << {addr_lo, 3'b000};
            end
            ST_SH: begin
                store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_data = {16'b0, store_src[15:0]} << {addr_lo[1], 4'b0000};
            end
            ST_SW: begin
                store_mask = 4'b1111;
                store_data = store_src;
            end
            default: store_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// RV32I single-cycle execute unit: write-back, memory request, branch next-PC; status flags registered.
// Latency: all outputs combinational except zero/negative/overflow flags (one clk).
// Backpressure: none; no handshake.
module alu
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_control,
    input  logic [3:0]  input_type,
    input  logic [31:0] data_read,
    input  logic [31:0] instruction_addr,
    output logic [31:0] reg_write_data,
    output logic        register_write_valid,
    output logic [31:0] data_addr,
    output logic [31:0] data_write,
    output logic [3:0]  data_write_byte,
    output logic        data_read_valid,
    output logic        data_write_valid,
    output logic [31:0] iaddr_val,
    output logic        zero_flag,
    output logic        negative_flag,
    output logic        overflow_flag
);

    input_type_e typ;
    alu_op_e     alu_op;
    logic [31:0] op_b, sum, diff, alu_res;
    logic [31:0] mem_addr, pc_plus4, pc_target;
    logic [31:0] load_data, store_data, flag_res;
    logic [3:0]  store_mask;
    logic [4:0]  shamt;
    logic        load_ok, store_ok, br_taken, add_ovf, sub_ovf, flag_ovf;

    assign typ       = input_type_e'(input_type);
    assign alu_op    = decode_alu_op(typ, alu_control);
    assign op_b      = (typ == IT_I) ? imm : read_data2;
    assign shamt     = op_b[4:0];
    assign sum       = read_data1 + op_b;
    assign diff      = read_data1 - op_b;
    assign mem_addr  = read_data1 + imm;
    assign pc_plus4  = instruction_addr + 32'd4;
    assign pc_target = instruction_addr + imm;
    assign add_ovf   = (read_data1[31] == op_b[31]) && (sum[31] != read_data1[31]);
    assign sub_ovf   = (read_data1[31] != op_b[31]) && (diff[31] != read_data1[31]);

    alu_lsu_align u_lsu_align (
        .addr_lo    (mem_addr[1:0]),
        .code       (alu_control),
        .data_read  (data_read),
        .store_src  (read_data2),
        .load_data  (load_data),
        .load_ok    (load_ok),
        .store_data (store_data),
        .store_mask (store_mask),
        .store_ok   (store_ok)
    );

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLL:  alu_res = read_data1 << shamt;
            OP_SLT:  alu_res = {31'b0, $signed(read_data1) < $signed(op_b)};
            OP_SLTU: alu_res = {31'b0, read_data1 < op_b};
            OP_XOR:  alu_res = read_data1 ^ op_b;
            OP_SRL:  alu_res = read_data1 >> shamt;
            OP_SRA:  alu_res = 32'($signed(read_data1) >>> shamt);
            OP_OR:   alu_res = read_data1 | op_b;
            OP_AND:  alu_res = read_data1 & op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (alu_control)
            BR_BEQ:  br_taken = (read_data1 == read_data2);
            BR_BNE:  br_taken = (read_data1 != read_data2);
            BR_BLT:  br_taken = ($signed(read_data1) <  $signed(read_data2));
            BR_BGE:  br_taken = ($signed(read_data1) >= $signed(read_data2));
            BR_BLTU: br_taken = (read_data1 <  read_data2);
            BR_BGEU: br_taken = (read_data1 >= read_data2);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        reg_write_data       = '0;
        register_write_valid = 1'b0;
        data_addr            = '0;
        data_write           = '0;
        data_write_byte      = '0;
        data_read_valid      = 1'b0;
        data_write_valid     = 1'b0;
        iaddr_val            = pc_plus4;
        flag_ovf             = 1'b0;
        case (typ)
            IT_R, IT_I: begin
                if (alu_op != OP_NONE) begin
                    reg_write_data       = alu_res;
                    register_write_valid = 1'b1;
                end
                if (alu_op == OP_ADD) flag_ovf = add_ovf;
                if (alu_op == OP_SUB) flag_ovf = sub_ovf;
            end
            IT_LOAD: if (load_ok) begin
                data_addr            = mem_addr;
                data_read_valid      = 1'b1;
                reg_write_data       = load_data;
                register_write_valid = 1'b1;
            end
            IT_STORE: if (store_ok) begin
                data_addr        = mem_addr;
                data_write       = store_data;
                data_write_byte  = store_mask;
                data_write_valid = 1'b1;
            end
            IT_BRANCH: if (br_taken) iaddr_val = pc_target;
            IT_JALR, IT_JAL: begin
                reg_write_data       = pc_plus4;
                register_write_valid = 1'b1;
            end
            IT_AUIPC: begin
                reg_write_data       = pc_target;
                register_write_valid = 1'b1;
            end
            IT_LUI: begin
                reg_write_data       = imm;
                register_write_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Branches report the compare difference; everything else reports the write-back value.
    assign flag_res = (typ == IT_BRANCH) ? diff : reg_write_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            zero_flag     <= (flag_res == 32'd0);
            negative_flag <= flag_res[31];
            overflow_flag <= flag_ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: a behavioural reference model checked every cycle plus literal expectations.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] read_data1, read_data2, imm, data_read, instruction_addr;
    logic [3:0]  alu_control, input_type;
    logic [31:0] reg_write_data, data_addr, data_write, iaddr_val;
    logic        register_write_valid, data_read_valid, data_write_valid;
    logic [3:0]  data_write_byte;
    logic        zero_flag, negative_flag, overflow_flag;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    alu dut (
        .clk                  (clk),
        .reset                (reset),
        .read_data1           (read_data1),
        .read_data2           (read_data2),
        .imm                  (imm),
        .alu_control          (alu_control),
        .input_type           (input_type),
        .data_read            (data_read),
        .instruction_addr     (instruction_addr),
        .reg_write_data       (reg_write_data),
        .register_write_valid (register_write_valid),
        .data_addr            (data_addr),
        .data_write           (data_write),
        .data_write_byte      (data_write_byte),
        .data_read_valid      (data_read_valid),
        .data_write_valid     (data_write_valid),
        .iaddr_val            (iaddr_val),
        .zero_flag            (zero_flag),
        .negative_flag        (negative_flag),
        .overflow_flag        (overflow_flag)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        rwv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rv;
        logic        wv;
        logic [31:0] npc;
    } comb_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic string op_name(input logic [3:0] t, input logic [3:0] c);
        if (t == 4'd0) begin
            case (c)
                4'd0: return "ADD";  4'd1: return "SUB";  4'd2: return "SLL";
                4'd3: return "SLT";  4'd4: return "SLTU"; 4'd5: return "XOR";
                4'd6: return "SRL";  4'd7: return "SRA";  4'd8: return "OR";
                4'd9: return "AND";
                default: return "";
            endcase
        end
        if (t == 4'd1) begin
            case (c)
                4'd0: return "ADD";  4'd1: return "SLL";  4'd2: return "SLT";
                4'd3: return "SLTU"; 4'd4: return "XOR";  4'd5: return "SRL";
                4'd6: return "SRA";  4'd7: return "OR";   4'd8: return "AND";
                default: return "";
            endcase
        end
        return "";
    endfunction

    function automatic logic [31:0] alu_eval(input string op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (op == "ADD")  return 32'(sa + sb);
        if (op == "SUB")  return 32'(sa - sb);
        if (op == "SLL")  return a << b[4:0];
        if (op == "SLT")  return (sa < sb) ? 32'd1 : 32'd0;
        if (op == "SLTU") return ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
        if (op == "XOR")  return a ^ b;
        if (op == "SRL")  return a >> b[4:0];
        if (op == "SRA")  return 32'($signed(a) >>> b[4:0]);
        if (op == "OR")   return a | b;
        return a & b;
    endfunction

    function automatic comb_t model(input logic [3:0] t, input logic [3:0] c, input logic [31:0] r1,
                                    input logic [31:0] r2, input logic [31:0] im, input logic [31:0] dr,
                                    input logic [31:0] pc);
        comb_t e;
        string op;
        logic [7:0]  lanes [4];
        logic [31:0] ea;
        int k;
        e = '0;
        e.npc = pc + 32'd4;
        op = op_name(t, c);
        ea = r1 + im;
        k = int'(ea[1:0]);
        for (int i = 0; i < 4; i++) lanes[i] = dr[8*i +: 8];
        if (op != "") begin
            e.rd  = alu_eval(op, r1, (t == 4'd1) ? im : r2);
            e.rwv = 1'b1;
        end else if (t == 4'd2 && c <= 4'd4) begin
            e.addr = ea; e.rv = 1'b1; e.rwv = 1'b1;
            case (c)
                4'd0: e.rd = 32'($signed(lanes[k]));
                4'd1: e.rd = 32'($signed({lanes[(k/2)*2+1], lanes[(k/2)*2]}));
                4'd2: e.rd = dr;
                4'd3: e.rd = {24'b0, lanes[k]};
                default: e.rd = {16'b0, lanes[(k/2)*2+1], lanes[(k/2)*2]};
            endcase
        end else if (t == 4'd3 && c <= 4'd2) begin
            e.addr = ea; e.wv = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if ((c == 4'd0 && i == k) || (c == 4'd1 && i / 2 == k / 2) || c == 4'd2) begin
                    e.be[i] = 1'b1;
                    e.wdata[8*i +: 8] = r2[8*(i - ((c == 4'd0) ? k : (c == 4'd1) ? (k/2)*2 : 0)) +: 8];
                end
            end
        end else if (t == 4'd4) begin
            longint s1 = longint'($signed(r1));
            longint s2 = longint'($signed(r2));
            bit tk;
            case (c)
                4'd0: tk = (r1 == r2);
                4'd1: tk = (r1 != r2);
                4'd4: tk = (s1 < s2);
                4'd6: tk = (s1 >= s2);
                4'd7: tk = ({32'b0, r1} <  {32'b0, r2});
                4'd8: tk = ({32'b0, r1} >= {32'b0, r2});
                default: tk = 1'b0;
            endcase
            if (tk) e.npc = pc + im;
        end else if (t == 4'd5 || t == 4'd6) begin
            e.rd = pc + 32'd4; e.rwv = 1'b1;
        end else if (t == 4'd7) begin
            e.rd = pc + im; e.rwv = 1'b1;
        end else if (t == 4'd8) begin
            e.rd = im; e.rwv = 1'b1;
        end
        return e;
    endfunction

    // Expected flags {zero, negative, overflow} as they must appear after a clock edge.
    function automatic logic [2:0] model_flags(input logic [3:0] t, input logic [3:0] c, input logic [31:0] r1,
                                               input logic [31:0] r2, input logic [31:0] im,
                                               input logic [31:0] dr, input logic [31:0] pc);
        comb_t e;
        logic [31:0] res;
        longint wide;
        string op;
        logic ov;
        e   = model(t, c, r1, r2, im, dr, pc);
        res = (t == 4'd4) ? r1 - r2 : e.rd;
        op  = op_name(t, c);
        ov  = 1'b0;
        if (op == "ADD" || op == "SUB") begin
            wide = (op == "ADD") ? longint'($signed(r1)) + longint'($signed((t == 4'd1) ? im : r2))
                                 : longint'($signed(r1)) - longint'($signed(r2));
            ov = (wide > SMAX) || (wide < SMIN);
        end
        return {res == 32'd0, res[31], ov};
    endfunction

    logic [2:0] exp_flags = 3'b000;
    comb_t act_c, exp_c;

    always @(posedge clk) begin
        if (reset) exp_flags = 3'b000;
        else exp_flags = model_flags(input_type, alu_control, read_data1, read_data2, imm,
                                     data_read, instruction_addr);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            act_c = {reg_write_data, register_write_valid, data_addr, data_write, data_write_byte,
                     data_read_valid, data_write_valid, iaddr_val};
            exp_c = model(input_type, alu_control, read_data1, read_data2, imm, data_read, instruction_addr);
            total++;
            if (act_c !== exp_c) begin
                bad++;
                $display("FAIL model_comb t=%0d c=%0d: got %h want %h", input_type, alu_control, act_c, exp_c);
            end
            total++;
            if ({zero_flag, negative_flag, overflow_flag} !== exp_flags) begin
                bad++;
                $display("FAIL model_flags: got %b want %b", {zero_flag, negative_flag, overflow_flag}, exp_flags);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic [3:0] c, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] dr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        input_type = t; alu_control = c; read_data1 = r1; read_data2 = r2;
        imm = im; data_read = dr; instruction_addr = pc;
        @(negedge clk);
    endtask

    task automatic chk_flags(input string nm, input logic [2:0] want);
        @(posedge clk);
        #1;
        chk(nm, {29'b0, zero_flag, negative_flag, overflow_flag}, {29'b0, want});
    endtask

    comb_t m;

    initial begin
        reset = 1'b1;
        input_type = 4'd0; alu_control = 4'd0; read_data1 = '0; read_data2 = '0;
        imm = '0; data_read = '0; instruction_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags_init", {29'b0, zero_flag, negative_flag, overflow_flag}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        m = model(4'd0, 4'd1, 32'd11, 32'd22, 32'd0, 32'd0, 32'd0);
        chk("pin_model_sub", m.rd, 32'hFFFFFFF5);
        m = model(4'd3, 4'd0, 32'd13, 32'hAB, 32'd5, 32'd0, 32'd0);
        chk("pin_model_sb", m.wdata, 32'h00AB0000);

        drive(4'd0, 4'd0, 32'd11, 32'd22, 32'd0, 32'd0, 32'd0);
        chk("add_rd", reg_write_data, 32'd33);
        chk("add_we", 32'(register_write_valid), 32'd1);
        drive(4'd0, 4'd1, 32'd11, 32'd22, 32'd0, 32'd0, 32'd0);
        chk("sub_rd", reg_write_data, 32'hFFFFFFF5);
        chk_flags("sub_flags", 3'b010);
        drive(4'd0, 4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        chk("add_ovf_rd", reg_write_data, 32'h80000000);
        chk_flags("add_ovf_flags", 3'b011);

        drive(4'd2, 4'd0, 32'd0, 32'd0, 32'd0, 32'h80000080, 32'd0);
        chk("lb_rd", reg_write_data, 32'hFFFFFF80);
        chk("lb_rv", 32'(data_read_valid), 32'd1);
        drive(4'd2, 4'd3, 32'd0, 32'd0, 32'd0, 32'h80000080, 32'd0);
        chk("lbu_rd", reg_write_data, 32'h00000080);
        drive(4'd2, 4'd1, 32'd0, 32'd0, 32'd2, 32'h80000080, 32'd0);
        chk("lh_hi_rd", reg_write_data, 32'hFFFF8000);
        drive(4'd2, 4'd4, 32'd0, 32'd0, 32'd3, 32'h80000080, 32'd0);
        chk("lhu_odd_rd", reg_write_data, 32'h00008000);
        drive(4'd2, 4'd2, 32'd0, 32'd0, 32'd1, 32'h80000080, 32'd0);
        chk("lw_rd", reg_write_data, 32'h80000080);

        drive(4'd3, 4'd0, 32'd11, 32'hAB, 32'd5, 32'd0, 32'd0);
        chk("sb0_addr", data_addr, 32'd16);
        chk("sb0_be", 32'(data_write_byte), 32'h1);
        chk("sb0_data", data_write, 32'h000000AB);
        drive(4'd3, 4'd0, 32'd13, 32'hAB, 32'd5, 32'd0, 32'd0);
        chk("sb2_be", 32'(data_write_byte), 32'h4);
        chk("sb2_data", data_write, 32'h00AB0000);
        chk("sb2_we", 32'(data_write_valid), 32'd1);
        drive(4'd3, 4'd1, 32'd2, 32'h1234ABCD, 32'd0, 32'd0, 32'd0);
        chk("sh_hi_be", 32'(data_write_byte), 32'hC);
        chk("sh_hi_data", data_write, 32'hABCD0000);
        drive(4'd3, 4'd2, 32'd4, 32'h1234ABCD, 32'd0, 32'd0, 32'd0);
        chk("sw_be", 32'(data_write_byte), 32'hF);

        drive(4'd4, 4'd0, 32'd5, 32'd5, 32'h10, 32'd0, 32'h100);
        chk("beq_npc", iaddr_val, 32'h110);
        chk("beq_nowb", 32'(register_write_valid), 32'd0);
        chk_flags("beq_flags", 3'b100);
        drive(4'd4, 4'd1, 32'd5, 32'd5, 32'h10, 32'd0, 32'h100);
        chk("bne_npc", iaddr_val, 32'h104);
        drive(4'd4, 4'd7, 32'd1, 32'hFFFFFFFF, 32'h10, 32'd0, 32'h100);
        chk("bltu_npc", iaddr_val, 32'h110);
        drive(4'd4, 4'd4, 32'd1, 32'hFFFFFFFF, 32'h10, 32'd0, 32'h100);
        chk("blt_npc", iaddr_val, 32'h104);
        drive(4'd4, 4'd6, 32'd1, 32'hFFFFFFFF, 32'h10, 32'd0, 32'h100);
        chk("bge_npc", iaddr_val, 32'h110);
        drive(4'd4, 4'd8, 32'd1, 32'hFFFFFFFF, 32'h10, 32'd0, 32'h100);
        chk("bgeu_npc", iaddr_val, 32'h104);

        drive(4'd6, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h40);
        chk("jal_rd", reg_write_data, 32'h44);
        drive(4'd5, 4'd0, 32'd0, 32'd0, 32'd8, 32'd0, 32'h80);
        chk("jalr_rd", reg_write_data, 32'h84);
        drive(4'd7, 4'd0, 32'd0, 32'd0, 32'h2000, 32'd0, 32'h1000);
        chk("auipc_rd", reg_write_data, 32'h3000);
        drive(4'd8, 4'd0, 32'd0, 32'd0, 32'h12345000, 32'd0, 32'h40);
        chk("lui_rd", reg_write_data, 32'h12345000);

        drive(4'd1, 4'd6, 32'h80000000, 32'd0, 32'd4, 32'd0, 32'd0);
        chk("srai_rd", reg_write_data, 32'hF8000000);
        drive(4'd1, 4'd3, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0);
        chk("sltiu_rd", reg_write_data, 32'd1);
        drive(4'd1, 4'd2, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0);
        chk("slti_rd", reg_write_data, 32'd0);
        drive(4'd1, 4'd9, 32'd7, 32'd0, 32'd7, 32'd0, 32'd0);
        chk("i_undef_we", 32'(register_write_valid), 32'd0);
        drive(4'd9, 4'd0, 32'd7, 32'd7, 32'd7, 32'd0, 32'h200);
        chk("type_undef_npc", iaddr_val, 32'h204);
        chk("type_undef_we", 32'(register_write_valid | data_read_valid | data_write_valid), 32'd0);

        drive(4'd0, 4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        chk_flags("pre_reset_flags", 3'b011);
        reset = 1'b1;
        chk_flags("reset_flags", 3'b000);
        chk("reset_comb_rd", reg_write_data, 32'h80000000);
        reset = 1'b0;
        drive(4'd0, 4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 32'd0);
        chk("xor_rd", reg_write_data, 32'hFF00FF00);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
